cpu_debug_display_ctrl: RTL

//  Next-generation debug front end for the teaching CPUs. It replaces the bare single-step clock gate with a

---
 rtl/cpu_debug_display_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_debug_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_debug_display_ctrl: step/burst/run/breakpoint controller + LCD mux   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_debug_display_ctrl #(
  parameter int NUM_REGS       = 32,
  parameter int FIRST_REG_SLOT = 5,
  parameter int DEBOUNCE_CYC   = 16,
  parameter int RA_W           = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            btn_step,
  input  logic [1:0]      mode,
  input  logic [31:0]     cpu_pc,
  input  logic [31:0]     cpu_inst,
  input  logic [31:0]     rf_data,
  input  logic [31:0]     mem_data,
  input  logic [5:0]      display_number,
  input  logic            input_valid,
  input  logic [31:0]     input_value,
  output logic            cpu_clk_en,
  output logic [RA_W-1:0] rf_addr,
  output logic [31:0]     mem_addr,
  output logic            halted,
  output logic            display_valid,
  output logic [39:0]     display_name,
  output logic [31:0]     display_value
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STEP    = 3'd1,
    ST_BURST   = 3'd2,
    ST_RUN     = 3'd3,
    ST_BRK_EN  = 3'd4,
    ST_BRK_CHK = 3'd5
  } state_t;

  localparam int         c_db_w       = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [c_db_w-1:0] c_db_max = c_db_w'(DEBOUNCE_CYC - 1);
  localparam logic [5:0] c_first_slot = 6'(FIRST_REG_SLOT);
  localparam logic [5:0] c_s_bp       = 6'(FIRST_REG_SLOT + NUM_REGS);
  localparam logic [5:0] c_s_nstep    = 6'(FIRST_REG_SLOT + NUM_REGS + 1);
  localparam logic [5:0] c_s_steps    = 6'(FIRST_REG_SLOT + NUM_REGS + 2);
  localparam logic [5:0] c_s_state    = 6'(FIRST_REG_SLOT + NUM_REGS + 3);

  logic              r_btn_meta, r_btn_sync, r_db_level, r_press;
  logic [c_db_w-1:0] r_db_cnt;
  state_t            r_state;
  logic [15:0]       r_remaining, r_burst_n;
  logic [31:0]       r_bp_addr, r_step_cnt;
  logic [5:0]        w_reg_off, w_tens, w_ones;
  logic              w_in_regs;

  // Level only flips after DEBOUNCE_CYC consecutive samples disagree with it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_btn_meta <= btn_step;
      r_btn_sync <= r_btn_meta;
      r_press    <= 1'b0;
      if (r_btn_sync == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_db_max) begin
        r_db_level <= r_btn_sync;
        r_db_cnt   <= '0;
        r_press    <= r_btn_sync;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // cpu_clk_en is high for exactly the cycles spent in an enabling state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      cpu_clk_en  <= 1'b0;
      r_remaining <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          cpu_clk_en <= 1'b0;
          if (r_press) begin
            unique case (mode)
              2'b00: begin r_state <= ST_STEP; cpu_clk_en <= 1'b1; end
              2'b01: begin
                r_remaining <= r_burst_n;
                if (r_burst_n != 16'd0) begin
                  r_state    <= ST_BURST;
                  cpu_clk_en <= 1'b1;
                end
              end
              2'b10: begin r_state <= ST_RUN;    cpu_clk_en <= 1'b1; end
              default: begin r_state <= ST_BRK_EN; cpu_clk_en <= 1'b1; end
            endcase
          end
        end
        ST_STEP: begin
          r_state    <= ST_IDLE;
          cpu_clk_en <= 1'b0;
        end
        ST_BURST: begin
          r_remaining <= r_remaining - 16'd1;
          if (r_press || r_remaining == 16'd1) begin
            r_state    <= ST_IDLE;
            cpu_clk_en <= 1'b0;
          end else begin
            cpu_clk_en <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_press) begin
            r_state    <= ST_IDLE;
            cpu_clk_en <= 1'b0;
          end else begin
            cpu_clk_en <= 1'b1;
          end
        end
        ST_BRK_EN: begin
          cpu_clk_en <= 1'b0;
          r_state    <= r_press ? ST_IDLE : ST_BRK_CHK;
        end
        ST_BRK_CHK: begin
          if (r_press || cpu_pc == r_bp_addr) begin
            r_state    <= ST_IDLE;
            cpu_clk_en <= 1'b0;
          end else begin
            r_state    <= ST_BRK_EN;
            cpu_clk_en <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          cpu_clk_en <= 1'b0;
        end
      endcase
    end
  end

  assign halted = (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_step_cnt <= '0;
    end else if (cpu_clk_en) begin
      r_step_cnt <= r_step_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr  <= '0;
      r_bp_addr <= 32'hFFFF_FFFF;
      r_burst_n <= 16'd1;
    end else if (input_valid) begin
      if (display_number == 6'd3)      mem_addr  <= input_value;
      if (display_number == c_s_bp)    r_bp_addr <= input_value;
      if (display_number == c_s_nstep) r_burst_n <= input_value[15:0];
    end
  end

  assign w_reg_off = display_number - c_first_slot;
  assign rf_addr   = w_reg_off[RA_W-1:0];
  assign w_in_regs = (display_number >= c_first_slot) && (display_number < c_s_bp);
  assign w_tens    = w_reg_off / 6'd10;
  assign w_ones    = w_reg_off % 6'd10;

  // Invalid slots leave name/value untouched so the LCD keeps its last text.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      display_valid <= 1'b1;
      if (w_in_regs) begin
        display_name  <= {"REG", 8'h30 + {2'b00, w_tens}, 8'h30 + {2'b00, w_ones}};
        display_value <= rf_data;
      end else begin
        case (display_number)
          6'd1:      begin display_name <= "   PC"; display_value <= cpu_pc;   end
          6'd2:      begin display_name <= " INST"; display_value <= cpu_inst; end
          6'd3:      begin display_name <= "MADDR"; display_value <= mem_addr; end
          6'd4:      begin display_name <= "MDATA"; display_value <= mem_data; end
          c_s_bp:    begin display_name <= " BKPT"; display_value <= r_bp_addr; end
          c_s_nstep: begin display_name <= "NSTEP"; display_value <= {16'b0, r_burst_n}; end
          c_s_steps: begin display_name <= "STEPS"; display_value <= r_step_cnt; end
          c_s_state: begin display_name <= "STATE"; display_value <= {29'b0, r_state}; end
          default:   display_valid <= 1'b0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
